// File: rtl/ring_decoder.sv
// rtl/ring_decoder.sv - one-hot ring code decoder, successor checker and lock monitor (option: RING_DECODER_BIDIR_EN)
module ring_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int REV_W    = 8,
  parameter int ERR_W    = 8,
  parameter int IDX_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             init,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             ring_valid,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             illegal,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [REV_W-1:0] rev_count,
`ifdef RING_DECODER_BIDIR_EN
  output logic             dir,
`endif
  output logic [ERR_W-1:0] err_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t           state_q, state_d;
  // last legal sample; the expected code is derived from it by rotation
  logic [WIDTH-1:0] last_q, last_d;
  logic [MW-1:0]    match_q, match_d;
  logic             dir_q, dir_d;

  logic [IDX_W-1:0] idx_d;
  logic             idx_valid_d, illegal_d, err_d, wrap_d;
  logic [REV_W-1:0] rev_d;
  logic [ERR_W-1:0] errc_d;

  logic             legal;
  logic [IDX_W-1:0] pos;
  logic [WIDTH-1:0] rotl, rotr;
  logic             hit, hit_dir, wrap_bit;

  // decode the sample and decide whether it is the expected successor
  always_comb begin
    legal = (ring_in != '0) && ((ring_in & (ring_in - 1'b1)) == '0);
    pos   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) pos = i[IDX_W-1:0];
    end
    rotl = {last_q[WIDTH-2:0], last_q[WIDTH-1]};
    rotr = {last_q[0], last_q[WIDTH-1:1]};
    hit     = 1'b0;
    hit_dir = dir_q;
`ifdef RING_DECODER_BIDIR_EN
    // first successor after a (re)seed picks the direction; left wins a tie
    if (state_q == CHECK && match_q == '0) begin
      if (ring_in == rotl) begin
        hit     = 1'b1;
        hit_dir = 1'b0;
      end else if (ring_in == rotr) begin
        hit     = 1'b1;
        hit_dir = 1'b1;
      end
    end else begin
      hit = (ring_in == (dir_q ? rotr : rotl));
    end
`else
    hit     = (ring_in == rotl);
    hit_dir = 1'b0;
`endif
    wrap_bit = hit_dir ? ring_in[WIDTH-1] : ring_in[0];
  end

  // next-state, next-output and counter update
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    match_d     = match_q;
    dir_d       = dir_q;
    idx_d       = idx;
    idx_valid_d = 1'b0;
    illegal_d   = 1'b0;
    err_d       = 1'b0;
    wrap_d      = 1'b0;
    rev_d       = rev_count;
    errc_d      = err_count;
    if (ring_valid) begin
      if (!legal) begin
        illegal_d = 1'b1;
        err_d     = (state_q == LOCKED);
        state_d   = HUNT;
        match_d   = '0;
      end else begin
        idx_d       = pos;
        idx_valid_d = 1'b1;
        last_d      = ring_in;
        case (state_q)
          HUNT: begin
            state_d = CHECK;
            match_d = '0;
          end
          CHECK: begin
            if (hit) begin
              match_d = match_q + 1'b1;
              dir_d   = hit_dir;
              if (int'(match_q) + 1 >= LOCK_CNT) state_d = LOCKED;
            end else begin
              match_d = '0;
            end
          end
          LOCKED: begin
            if (hit) begin
              wrap_d = wrap_bit;
            end else begin
              err_d   = 1'b1;
              state_d = CHECK;
              match_d = '0;
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
    if (wrap_d) rev_d = rev_count + 1'b1;
    if (err_d && !(&err_count)) errc_d = err_count + 1'b1;
  end

  // registered state and outputs; init overrides everything
  always_ff @(posedge clk) begin
    if (init) begin
      state_q   <= HUNT;
      last_q    <= '0;
      match_q   <= '0;
      dir_q     <= 1'b0;
      idx       <= '0;
      idx_valid <= 1'b0;
      illegal   <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      wrap      <= 1'b0;
      rev_count <= '0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      match_q   <= match_d;
      dir_q     <= dir_d;
      idx       <= idx_d;
      idx_valid <= idx_valid_d;
      illegal   <= illegal_d;
      locked    <= (state_d == LOCKED);
      err       <= err_d;
      wrap      <= wrap_d;
      rev_count <= rev_d;
      err_count <= errc_d;
    end
  end

`ifdef RING_DECODER_BIDIR_EN
  assign dir = dir_q;
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// tb/tb_ring_decoder.sv - randomized self-checking bench for ring_decoder against a positional model
module tb_ring_decoder;

  localparam int W   = 4;
  localparam int LC  = 2;
  localparam int RW  = 8;
  localparam int EW  = 2;

  logic         clk = 1'b0;
  logic         init = 1'b0;
  logic [W-1:0] ring_in = '0;
  logic         ring_valid = 1'b0;
  logic [1:0]   idx;
  logic         idx_valid, illegal, locked, err, wrap;
  logic [RW-1:0] rev_count;
  logic [EW-1:0] err_count;
`ifdef RING_DECODER_BIDIR_EN
  logic         dir;
`endif

  ring_decoder #(.WIDTH(W), .LOCK_CNT(LC), .REV_W(RW), .ERR_W(EW)) dut (
    .clk(clk), .init(init), .ring_in(ring_in), .ring_valid(ring_valid),
    .idx(idx), .idx_valid(idx_valid), .illegal(illegal), .locked(locked),
    .err(err), .wrap(wrap), .rev_count(rev_count),
`ifdef RING_DECODER_BIDIR_EN
    .dir(dir),
`endif
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // model: ring position as an integer, step +1 (left) or -1 (right)
  bit m_have, m_locked;
  int m_pos, m_run, m_step, m_idx, m_rev, m_err;
  bit m_iv, m_ill, m_errp, m_wrap;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have = 0; m_locked = 0; m_pos = 0; m_run = 0; m_step = 1;
    m_idx = 0; m_rev = 0; m_err = 0;
    m_iv = 0; m_ill = 0; m_errp = 0; m_wrap = 0;
  endtask

  task automatic model_apply(input bit v, input logic [W-1:0] code);
    int p, fwd, bwd, nstep;
    bit ok;
    m_iv = 0; m_ill = 0; m_errp = 0; m_wrap = 0;
    if (!v) return;
    if ($countones(code) != 1) begin
      m_ill = 1;
      m_errp = m_locked;
      m_locked = 0; m_have = 0; m_run = 0;
    end else begin
      p = 0;
      for (int i = 0; i < W; i++) if (code[i]) p = i;
      m_idx = p; m_iv = 1;
      if (!m_have) begin
        m_have = 1; m_run = 0;
      end else begin
        fwd = (m_pos + 1) % W;
        bwd = (m_pos + W - 1) % W;
        nstep = m_step;
`ifdef RING_DECODER_BIDIR_EN
        if (!m_locked && m_run == 0) begin
          if (p == fwd) begin ok = 1; nstep = 1; end
          else if (p == bwd) begin ok = 1; nstep = -1; end
          else ok = 0;
        end else begin
          ok = (p == ((m_step == 1) ? fwd : bwd));
        end
`else
        ok = (p == fwd);
`endif
        if (m_locked) begin
          if (ok) m_wrap = (m_step == 1) ? (p == 0) : (p == W - 1);
          else begin m_errp = 1; m_locked = 0; m_run = 0; end
        end else begin
          if (ok) begin
            m_step = nstep;
            m_run++;
            if (m_run >= LC) m_locked = 1;
          end else m_run = 0;
        end
      end
      m_pos = p;
    end
    if (m_errp && m_err < (1 << EW) - 1) m_err++;
    if (m_wrap) m_rev = (m_rev + 1) % (1 << RW);
  endtask

  task automatic check_all();
    check_eq("idx",       32'(idx),       32'(m_idx));
    check_eq("idx_valid", 32'(idx_valid), 32'(m_iv));
    check_eq("illegal",   32'(illegal),   32'(m_ill));
    check_eq("locked",    32'(locked),    32'(m_locked));
    check_eq("err",       32'(err),       32'(m_errp));
    check_eq("wrap",      32'(wrap),      32'(m_wrap));
    check_eq("rev_count", 32'(rev_count), 32'(m_rev));
    check_eq("err_count", 32'(err_count), 32'(m_err));
`ifdef RING_DECODER_BIDIR_EN
    check_eq("dir",       32'(dir),       32'(m_step == -1));
`endif
  endtask

  task automatic apply(input bit v, input logic [W-1:0] code);
    @(negedge clk);
    init = 1'b0;
    ring_valid = v;
    ring_in = v ? code : W'($urandom);
    @(posedge clk);
    #1;
    model_apply(v, code);
    check_all();
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(1, 5);
    for (int i = 0; i < n; i++) apply(1'b0, '0);
  endtask

  task automatic do_init();
    @(negedge clk);
    init = 1'b1;
    ring_valid = 1'b1;
    ring_in = 4'b0001;
    @(posedge clk);
    #1;
    model_reset();
    check_all();
    check_eq("init_locked", 32'(locked), 32'd0);
  endtask

  logic [W-1:0] last_code, c;
  int r;

  initial begin
    model_reset();
    do_init();

    // lock
    apply(1, 4'b0001); apply(1, 4'b0010); apply(1, 4'b0100);
    check_eq("lock_locked", 32'(locked), 32'd1);
    check_eq("lock_idx", 32'(idx), 32'd2);

    // wrap
    apply(1, 4'b1000); apply(1, 4'b0001);
    check_eq("wrap_pulse", 32'(wrap), 32'd1);
    check_eq("wrap_idx", 32'(idx), 32'd0);
    check_eq("wrap_rev1", 32'(rev_count), 32'd1);
    apply(1, 4'b0010); apply(1, 4'b0100); apply(1, 4'b1000); apply(1, 4'b0001);
    check_eq("wrap_rev2", 32'(rev_count), 32'd2);

    // wrong successor
    apply(1, 4'b1000);
    check_eq("wrong_err", 32'(err), 32'd1);
    check_eq("wrong_errc", 32'(err_count), 32'd1);
    check_eq("wrong_unlock", 32'(locked), 32'd0);
    apply(1, 4'b0001); apply(1, 4'b0010);
    check_eq("relock", 32'(locked), 32'd1);

    // illegal codes
    apply(1, 4'b0011);
    check_eq("ill_pulse", 32'(illegal), 32'd1);
    check_eq("ill_err", 32'(err), 32'd1);
    check_eq("ill_idx_hold", 32'(idx), 32'd1);
    apply(1, 4'b0000);
    check_eq("zero_ill", 32'(illegal), 32'd1);
    check_eq("zero_noerr", 32'(err), 32'd0);
    check_eq("zero_errc", 32'(err_count), 32'd2);

    // gaps, then init while locked
    apply(1, 4'b0001); gap(); apply(1, 4'b0010); gap(); apply(1, 4'b0100); gap();
    apply(1, 4'b1000); gap(); apply(1, 4'b0001); gap();
    check_eq("gap_locked", 32'(locked), 32'd1);
    check_eq("gap_rev3", 32'(rev_count), 32'd3);
    do_init();
    check_eq("init_rev", 32'(rev_count), 32'd0);

    // saturation: five errors from LOCKED
    apply(1, 4'b0001); apply(1, 4'b0010); apply(1, 4'b0100);
    for (int k = 0; k < 5; k++) begin
      apply(1, 4'b0100);
      apply(1, 4'b1000); apply(1, 4'b0001);
    end
    check_eq("sat_errc", 32'(err_count), 32'd3);

`ifdef RING_DECODER_BIDIR_EN
    do_init();
    apply(1, 4'b1000); apply(1, 4'b0100); apply(1, 4'b0010);
    check_eq("bidir_locked", 32'(locked), 32'd1);
    check_eq("bidir_dir", 32'(dir), 32'd1);
`endif

    // randomized run with occasional init
    do_init();
    last_code = 4'b0001;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        do_init();
        continue;
      end else if (r < 15) begin
        apply(1'b0, '0);
        continue;
      end else if (r < 80) begin
        c = {last_code[W-2:0], last_code[W-1]};
      end else if (r < 86) begin
        c = {last_code[0], last_code[W-1:1]};
      end else if (r < 93) begin
        c = W'(1) << $urandom_range(0, W - 1);
      end else begin
        c = W'($urandom);
      end
      if ($countones(c) == 1) last_code = c;
      apply(1'b1, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
